// File: rtl/vinstru_mc_if.sv
// Capture-memory port of the pulse instrument: byte-addressed 32-bit BRAM write side.
// The instrument drives through the master modport; the memory uses the slave modport.
interface vinstru_mc_if #(
  parameter int DEPTH_LOG2 = 12
);
  logic                  bram_clk;
  logic                  bram_rst;
  logic                  bram_en;
  logic [3:0]            bram_we;
  logic [DEPTH_LOG2+1:0] bram_addr;
  logic [31:0]           bram_din;
  logic [31:0]           bram_dout;

  modport master (
    output bram_clk,
    output bram_rst,
    output bram_en,
    output bram_we,
    output bram_addr,
    output bram_din,
    input  bram_dout
  );

  modport slave (
    input  bram_clk,
    input  bram_rst,
    input  bram_en,
    input  bram_we,
    input  bram_addr,
    input  bram_din,
    output bram_dout
  );
endinterface

// File: rtl/vinstru_mc.sv
// Multi-channel pulse generator with LFSR noise that captures frames of DEPTH
// saturated samples into a BRAM, in single-shot or continuous re-arm mode.
module vinstru_mc #(
  parameter int NCH        = 4,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic              reset,
  input  logic              run,
  input  logic              mode,
  input  logic [NCH-1:0]    enable,
  input  logic [NCH*32-1:0] pulse_period,
  input  logic [NCH*16-1:0] pulse_width,
  input  logic [NCH*16-1:0] pulse_amplitude,
  input  logic [15:0]       noise_amplitude,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_count,
  vinstru_mc_if.master      bram
);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Nine 16-bit terms at most (8 channels + noise) fit in 20 signed bits.
  localparam int SUM_W = 20;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  state_reg, state_next;
  logic [DEPTH_LOG2-1:0]   cap_cnt_reg;
  logic                    drain_cnt_reg;
  logic                    run_reg;
  logic                    armed_reg;
  logic [15:0]             frame_count_reg;
  logic [15:0]             lfsr_reg;
  logic                    lfsr_fb;
  logic                    enter_capture;

  logic                    v1_reg;
  logic [DEPTH_LOG2-1:0]   k1_reg;
  logic [15:0]             k16;
  logic [NCH*16-1:0]       ch_bus;

  logic signed [31:0]      noise_prod;
  logic [15:0]             noise_w;
  logic signed [SUM_W-1:0] sum_full;
  logic [15:0]             sat_w;

  logic                    bram_en_reg;
  logic [3:0]              bram_we_reg;
  logic [DEPTH_LOG2+1:0]   bram_addr_reg;
  logic [31:0]             bram_din_reg;
  logic                    unused_dout;

  // ---------------- control FSM ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (run && !run_reg && armed_reg) state_next = S_CAPTURE;
      S_CAPTURE: if (cap_cnt_reg == {DEPTH_LOG2{1'b1}}) state_next = S_DRAIN;
      S_DRAIN:   if (drain_cnt_reg) state_next = S_DONE;
      S_DONE:    state_next = (mode && run) ? S_CAPTURE : S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  assign enter_capture = (state_next == S_CAPTURE) && (state_reg != S_CAPTURE);
  assign lfsr_fb       = lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5];

  // armed_reg demands that run be seen low after any reset before a new start.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_reg       <= S_IDLE;
      cap_cnt_reg     <= '0;
      drain_cnt_reg   <= 1'b0;
      run_reg         <= 1'b0;
      armed_reg       <= 1'b0;
      frame_count_reg <= 16'd0;
      lfsr_reg        <= LFSR_SEED;
    end else if (reset) begin
      state_reg       <= S_IDLE;
      cap_cnt_reg     <= '0;
      drain_cnt_reg   <= 1'b0;
      run_reg         <= 1'b0;
      armed_reg       <= 1'b0;
      frame_count_reg <= 16'd0;
      lfsr_reg        <= LFSR_SEED;
    end else begin
      state_reg     <= state_next;
      run_reg       <= run;
      lfsr_reg      <= {lfsr_fb, lfsr_reg[15:1]};
      cap_cnt_reg   <= (state_reg == S_CAPTURE) ? cap_cnt_reg + 1'b1 : '0;
      drain_cnt_reg <= (state_reg == S_DRAIN) ? ~drain_cnt_reg : 1'b0;
      if (!run) armed_reg <= 1'b1;
      if (state_next == S_DONE && state_reg != S_DONE)
        frame_count_reg <= frame_count_reg + 16'd1;
    end
  end

  assign busy        = (state_reg != S_IDLE);
  assign done        = (state_reg == S_DONE);
  assign frame_count = frame_count_reg;

  // ---------------- per-channel pulse generators (stage 1) ----------------
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [31:0]        period_w;
      logic [31:0]        period_eff;
      logic [15:0]        width_w;
      logic [15:0]        amp_w;
      logic [31:0]        phase_reg;
      logic [15:0]        ch_out_reg;

      assign period_w   = pulse_period[32*gi +: 32];
      assign period_eff = (period_w == 32'd0) ? 32'd1 : period_w;
      assign width_w    = pulse_width[16*gi +: 16];
      assign amp_w      = pulse_amplitude[16*gi +: 16];

      always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
          phase_reg  <= 32'd0;
          ch_out_reg <= 16'd0;
        end else if (reset) begin
          phase_reg  <= 32'd0;
          ch_out_reg <= 16'd0;
        end else begin
          if (enter_capture)
            phase_reg <= 32'd0;
          else if (state_reg == S_CAPTURE)
            phase_reg <= (phase_reg >= period_eff - 32'd1) ? 32'd0 : phase_reg + 32'd1;
          ch_out_reg <= (enable[gi] && (phase_reg < {16'd0, width_w})) ? amp_w : 16'd0;
        end
      end

      assign ch_bus[16*gi +: 16] = ch_out_reg;
    end

    if (DEPTH_LOG2 >= 16) begin : g_k_trunc
      assign k16 = k1_reg[15:0];
    end else begin : g_k_ext
      assign k16 = {{(16-DEPTH_LOG2){1'b0}}, k1_reg};
    end
  endgenerate

  // ---------------- noise, sum and saturation (stage 2) ----------------
  assign noise_prod = 32'($signed(lfsr_reg)) * 32'($signed({1'b0, noise_amplitude}));
  assign noise_w    = 16'(noise_prod >>> 16);

  always_comb begin
    sum_full = {{(SUM_W-16){noise_w[15]}}, noise_w};
    for (int i = 0; i < NCH; i++)
      sum_full = sum_full + {{(SUM_W-16){ch_bus[16*i+15]}}, ch_bus[16*i +: 16]};
    if (sum_full > 20'sd32767)
      sat_w = 16'h7FFF;
    else if (sum_full < -20'sd32768)
      sat_w = 16'h8000;
    else
      sat_w = sum_full[15:0];
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      v1_reg        <= 1'b0;
      k1_reg        <= '0;
      bram_en_reg   <= 1'b0;
      bram_we_reg   <= 4'h0;
      bram_addr_reg <= '0;
      bram_din_reg  <= 32'd0;
    end else if (reset) begin
      v1_reg        <= 1'b0;
      k1_reg        <= '0;
      bram_en_reg   <= 1'b0;
      bram_we_reg   <= 4'h0;
      bram_addr_reg <= '0;
      bram_din_reg  <= 32'd0;
    end else begin
      v1_reg      <= (state_reg == S_CAPTURE);
      k1_reg      <= cap_cnt_reg;
      bram_en_reg <= v1_reg;
      bram_we_reg <= {4{v1_reg}};
      if (v1_reg) begin
        bram_addr_reg <= {k1_reg, 2'b00};
        bram_din_reg  <= {k16, sat_w};
      end
    end
  end

  assign bram.bram_clk  = axi_aclk;
  assign bram.bram_rst  = 1'b0;
  assign bram.bram_en   = bram_en_reg;
  assign bram.bram_we   = bram_we_reg;
  assign bram.bram_addr = bram_addr_reg;
  assign bram.bram_din  = bram_din_reg;
  assign unused_dout    = ^bram.bram_dout;

endmodule

// File: tb/tb_vinstru_mc.sv
// Randomized bench for vinstru_mc: a frame-offset reference model checked every
// cycle, plus literal expectations for the directed frames.
module tb_vinstru_mc;
  localparam int NCH = 4;
  localparam int DL2 = 4;
  localparam int D   = 16;

  logic              axi_aclk = 1'b0;
  logic              axi_aresetn = 1'b0;
  logic              reset = 1'b0;
  logic              run = 1'b0;
  logic              mode = 1'b0;
  logic [NCH-1:0]    enable = '0;
  logic [NCH*32-1:0] pulse_period = '0;
  logic [NCH*16-1:0] pulse_width = '0;
  logic [NCH*16-1:0] pulse_amplitude = '0;
  logic [15:0]       noise_amplitude = '0;
  logic              busy, done;
  logic [15:0]       frame_count;

  vinstru_mc_if #(.DEPTH_LOG2(DL2)) bif ();
  assign bif.bram_dout = 32'd0;

  vinstru_mc #(.NCH(NCH), .DEPTH_LOG2(DL2)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .reset(reset), .run(run), .mode(mode),
    .enable(enable), .pulse_period(pulse_period), .pulse_width(pulse_width),
    .pulse_amplitude(pulse_amplitude), .noise_amplitude(noise_amplitude),
    .busy(busy), .done(done), .frame_count(frame_count), .bram(bif.master)
  );

  always #5 axi_aclk = ~axi_aclk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_in, m_nin, m_run_prev, m_armed;
  int          m_t, m_nt, m_fc;
  logic [15:0] m_lfsr;
  bit          e_busy, e_done, e_en;
  int          e_addr;
  logic [31:0] e_din;
  int          cyc = 0;

  function automatic logic [15:0] sample_sat(input int k, input logic [15:0] lf);
    int s;
    s = 0;
    for (int i = 0; i < NCH; i++) begin
      longint p;
      p = pulse_period[32*i +: 32];
      if (p == 0) p = 1;
      if (enable[i] && (k % p) < pulse_width[16*i +: 16])
        s += $signed(pulse_amplitude[16*i +: 16]);
    end
    s += ($signed(lf) * int'(noise_amplitude)) >>> 16;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  task automatic model_clear();
    m_in = 0; m_t = 0; m_run_prev = 0; m_armed = 0; m_fc = 0;
    m_lfsr = 16'hACE1;
    e_busy = 0; e_done = 0; e_en = 0; e_addr = 0; e_din = 0;
  endtask

  always @(posedge axi_aclk) cyc++;

  // Frame is tracked as an offset t from the first capture cycle: 0..D-1 capture,
  // D..D+1 drain, D+2 done; sample k is written at offset k+2.
  always @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn || reset) begin
      model_clear();
    end else begin
      m_nin = m_in;
      m_nt  = m_t;
      if (m_in) begin
        if (m_t == D + 2) begin
          if (mode && run) m_nt = 0;
          else m_nin = 0;
        end else begin
          m_nt = m_t + 1;
        end
      end else if (run && !m_run_prev && m_armed) begin
        m_nin = 1;
        m_nt  = 0;
      end
      e_busy = m_nin;
      e_done = m_nin && (m_nt == D + 2);
      if (e_done) m_fc = (m_fc + 1) & 16'hFFFF;
      e_en = m_nin && (m_nt >= 2) && (m_nt <= D + 1);
      if (e_en) begin
        e_addr = 4 * (m_nt - 2);
        e_din  = {16'(m_nt - 2), sample_sat(m_nt - 2, m_lfsr)};
      end
      m_in = m_nin;
      m_t  = m_nt;
      if (!run) m_armed = 1;
      m_run_prev = run;
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
  end

  // ---------------- per-cycle compare + write capture ----------------
  logic [31:0] wr_din [D];
  int          wr_cnt = 0;
  int          last_wr_cyc = 0;
  int          last_done_cyc = 0;

  always @(negedge axi_aclk) begin
    if (axi_aresetn) begin
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("frame_count", frame_count, m_fc);
      chk("bram_en", bif.bram_en, e_en);
      chk("bram_we", bif.bram_we, e_en ? 4'hF : 4'h0);
      chk("bram_rst", bif.bram_rst, 1'b0);
      chk("bram_clk", bif.bram_clk, axi_aclk);
      if (e_en) begin
        chk("bram_addr", bif.bram_addr, e_addr);
        chk("bram_din", bif.bram_din, e_din);
      end
      if (bif.bram_en) begin
        wr_din[bif.bram_addr[5:2]] = bif.bram_din;
        wr_cnt++;
        last_wr_cyc = cyc;
      end
      if (done) last_done_cyc = cyc;
    end
  end

  // ---------------- stimulus ----------------
  task automatic ticks(input int n);
    repeat (n) @(negedge axi_aclk);
  endtask

  task automatic wait_busy(input logic val, input int bound, input string name);
    int i;
    i = 0;
    while (busy !== val && i < bound) begin
      ticks(1);
      i++;
    end
    chk(name, busy, val);
  endtask

  task automatic wait_done(input int bound, input string name);
    int i;
    i = 0;
    while (done !== 1'b1 && i < bound) begin
      ticks(1);
      i++;
    end
    chk(name, done, 1'b1);
  endtask

  task automatic clear_params();
    enable = '0; pulse_period = '0; pulse_width = '0;
    pulse_amplitude = '0; noise_amplitude = '0;
  endtask

  task automatic set_ch(input int i, input int per, input int wid, input int amp, input bit en);
    pulse_period[32*i +: 32]    = per;
    pulse_width[16*i +: 16]     = wid[15:0];
    pulse_amplitude[16*i +: 16] = amp[15:0];
    enable[i]                   = en;
  endtask

  task automatic run_single(input string name);
    mode = 0; run = 0;
    ticks(2);
    wr_cnt = 0;
    run = 1;
    wait_busy(1'b1, 4, {name, " start"});
    wait_busy(1'b0, 40, {name, " end"});
    run = 0;
    ticks(1);
  endtask

  initial begin
    int fc0;
    int dc [3];
    model_clear();
    #3;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst frame_count", frame_count, 16'd0);
    chk("rst bram_en", bif.bram_en, 1'b0);
    chk("rst bram_addr", bif.bram_addr, 6'd0);
    chk("rst bram_din", bif.bram_din, 32'd0);
    ticks(2);
    axi_aresetn = 1'b1;
    ticks(2);

    // ch0 pulse train, period 4, width 1
    clear_params();
    set_ch(0, 4, 1, 100, 1'b1);
    run_single("pulse");
    chk("pulse writes", wr_cnt, 16);
    chk("pulse din0", wr_din[0], 32'h0000_0064);
    chk("pulse din1", wr_din[1], 32'h0001_0000);
    chk("pulse din4", wr_din[4], 32'h0004_0064);
    chk("pulse din12", wr_din[12], 32'h000C_0064);
    chk("pulse din15", wr_din[15], 32'h000F_0000);
    chk("pulse done after last write", last_done_cyc, last_wr_cyc + 1);
    chk("pulse frame_count", frame_count, 16'd1);

    // saturation high and low
    clear_params();
    for (int i = 0; i < NCH; i++) set_ch(i, 1, 1, 16'h7FFF, 1'b1);
    run_single("sat_pos");
    chk("sat_pos din0", wr_din[0], 32'h0000_7FFF);
    chk("sat_pos din7", wr_din[7], 32'h0007_7FFF);
    for (int i = 0; i < NCH; i++) set_ch(i, 1, 1, 16'h8000, 1'b1);
    run_single("sat_neg");
    chk("sat_neg din9", wr_din[9], 32'h0009_8000);

    // period 0 behaves as period 1
    clear_params();
    set_ch(0, 0, 0, 16'h1234, 1'b1);
    run_single("p0w0");
    chk("p0w0 din5", wr_din[5], 32'h0005_0000);
    set_ch(0, 0, 5, 16'h1234, 1'b1);
    run_single("p0w5");
    chk("p0w5 din10", wr_din[10], 32'h000A_1234);

    // random frames, with and without noise
    for (int f = 0; f < 12; f++) begin
      clear_params();
      for (int i = 0; i < NCH; i++)
        set_ch(i, $urandom_range(0, 20), $urandom_range(0, 24), $urandom, 1'($urandom));
      noise_amplitude = $urandom_range(0, 1) ? 16'($urandom) : 16'd0;
      run_single("rand");
    end

    // continuous mode
    clear_params();
    set_ch(1, 3, 2, -500, 1'b1);
    noise_amplitude = 16'h0400;
    fc0 = frame_count;
    mode = 1; run = 0;
    ticks(2);
    run = 1;
    for (int f = 0; f < 3; f++) begin
      wait_done(40, "cont done");
      dc[f] = cyc;
      if (f < 2) ticks(1);
    end
    chk("cont spacing 1", dc[1] - dc[0], 19);
    chk("cont spacing 2", dc[2] - dc[1], 19);
    chk("cont frame_count 3", frame_count, 16'(fc0 + 3));
    wr_cnt = 0;
    ticks(6);
    run = 0;
    wait_busy(1'b0, 40, "cont end");
    chk("cont frame4 writes", wr_cnt, 16);
    chk("cont frame_count 4", frame_count, 16'(fc0 + 4));
    ticks(5);
    chk("cont stays idle", busy, 1'b0);
    mode = 0;

    // soft reset mid-capture, run held high afterwards
    run = 0;
    ticks(2);
    run = 1;
    wait_busy(1'b1, 4, "srst start");
    ticks(5);
    reset = 1;
    ticks(1);
    reset = 0;
    chk("srst bram_en", bif.bram_en, 1'b0);
    chk("srst busy", busy, 1'b0);
    chk("srst done", done, 1'b0);
    chk("srst frame_count", frame_count, 16'd0);
    ticks(30);
    chk("srst no restart", busy, 1'b0);

    // asynchronous reset pulse between edges mid-capture
    run = 0;
    noise_amplitude = 16'hFFFF;
    ticks(2);
    run = 1;
    wait_busy(1'b1, 4, "arst start");
    ticks(4);
    @(posedge axi_aclk);
    #2 axi_aresetn = 1'b0;
    #1;
    chk("arst busy", busy, 1'b0);
    chk("arst done", done, 1'b0);
    chk("arst frame_count", frame_count, 16'd0);
    chk("arst bram_en", bif.bram_en, 1'b0);
    chk("arst bram_we", bif.bram_we, 4'h0);
    chk("arst bram_addr", bif.bram_addr, 6'd0);
    chk("arst bram_din", bif.bram_din, 32'd0);
    #1 axi_aresetn = 1'b1;
    ticks(1);
    run_single("noise after arst");
    chk("noise frame_count", frame_count, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vinstru_mc.md
VINSTRU_MC -- requirements
Module: vinstru_mc

Interface
REQ-001 Parameter NCH, default 4, number of pulse channels (1..8).
REQ-002 Parameter DEPTH_LOG2, default 12, capture depth is 2**DEPTH_LOG2 words (DEPTH).
REQ-003 axi_aclk  in  1  single clock for all logic.
REQ-004 axi_aresetn  in  1  asynchronous reset, active-low.
REQ-005 reset  in  1  synchronous soft reset from the register file, active-high.
REQ-006 run  in  1  capture request. A rising edge starts a capture; the level is used in continuous mode.
REQ-007 mode  in  1  0 = single capture, 1 = continuous re-arm.
REQ-008 enable  in  NCH  per-channel pulse enable.
REQ-009 pulse_period  in  NCH*32  per-channel period in cycles, unsigned; channel i occupies bits [32i+31:32i].
REQ-010 pulse_width  in  NCH*16  per-channel high time in cycles, unsigned.
REQ-011 pulse_amplitude  in  NCH*16  per-channel amplitude, signed two's complement.
REQ-012 noise_amplitude  in  16  noise scale, unsigned.
REQ-013 busy  out  1  high in CAPTURE, DRAIN or DONE.
REQ-014 done  out  1  high while the FSM is in DONE.
REQ-015 frame_count  out  16  count of completed frames; wraps at 16'hFFFF to 0.
REQ-016 bram_clk  out  1  equals axi_aclk. bram_rst  out  1  constant 0.
REQ-017 bram_en  out  1, bram_we  out  4, bram_addr  out  DEPTH_LOG2+2 (byte address), bram_din  out  32, bram_dout  in  32 (unused).

Function
REQ-018 The FSM SHALL have states IDLE, CAPTURE, DRAIN and DONE.
REQ-019 IDLE -> CAPTURE on the cycle after run is sampled 1 while the registered run was 0.
REQ-020 The FSM SHALL stay in CAPTURE for exactly DEPTH cycles, then go to DRAIN.
REQ-021 The FSM SHALL stay in DRAIN for exactly 2 cycles, then go to DONE.
REQ-022 DONE lasts 1 cycle; frame_count increments on entry to DONE.
REQ-023 Leaving DONE: if mode=1 and run=1, go to CAPTURE; otherwise go to IDLE.
REQ-024 Consequence: continuous frames repeat every DEPTH+3 cycles, and done is a 1-cycle pulse per frame.
REQ-025 Deasserting run mid-frame SHALL NOT abort the frame in either mode; the frame completes and then REQ-023 applies.
REQ-026 Each channel SHALL have a 32-bit phase counter, cleared to 0 on entry to CAPTURE and advancing once per CAPTURE cycle.
REQ-027 The phase counter wraps to 0 after reaching period-1; period=0 is treated as 1.
REQ-028 Channel output SHALL be amplitude when enable[i]=1 and counter<width, else 0; width>=period gives a constant amplitude.
REQ-029 Noise source: 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1, advancing every cycle in all states.
REQ-030 Noise term SHALL be bits [31:16] of the product signed(lfsr) * {1'b0,noise_amplitude}; noise_amplitude=0 gives exactly 0.
REQ-031 Sum of all channel outputs plus noise SHALL be computed at full precision with no intermediate overflow.
REQ-032 The sum SHALL be saturated to the range [-32768, 32767].
REQ-033 Pipeline: phase counter value k -> registered channel outputs -> registered saturated sum. The word written for sample k appears 2 cycles after its CAPTURE cycle.
REQ-034 bram_en=1 and bram_we=4'hF for exactly DEPTH consecutive cycles: CAPTURE cycle 2 through the last DRAIN cycle.
REQ-035 bram_en=0 and bram_we=0 in all other cycles.
REQ-036 Sample k (k=0..DEPTH-1) SHALL be written at bram_addr=4*k, with bram_din[15:0]=saturated sum and bram_din[31:16]=k[15:0].
REQ-037 Parameter inputs SHALL be sampled every cycle; a change mid-frame takes effect on the next sample.

Reset
REQ-038 axi_aresetn=0 SHALL immediately force: state IDLE; busy, done, bram_en, bram_we, bram_addr, bram_din and frame_count = 0; all phase counters 0; LFSR = 16'hACE1; registered run = 0.
REQ-039 reset=1 SHALL produce the same values as REQ-038 on the next clock edge, including mid-capture; bram_en is 0 in the cycle after reset is sampled.
REQ-040 After any reset, a new capture SHALL require a fresh run rising edge.

Verification (NCH=4, DEPTH_LOG2=4, DEPTH=16)
REQ-041 ch0 only: period=4, width=1, amp=100, noise=0, run 0->1 -> 16 writes.
- addr 0,4,...,60
- bram_din = {k,16'd100} for k=0,4,8,12; {k,16'd0} otherwise
- done pulses 1 cycle after the last write; frame_count=1
REQ-042 Saturation: all 4 channels width=period=1.
- amp=16'h7FFF -> every low half = 16'h7FFF
- amp=16'h8000 -> every low half = 16'h8000
REQ-043 ch0 period=0, width=0 -> all samples 0; ch0 period=0, width=5 -> all samples = amp.
REQ-044 mode=1, run held high for 3 frames -> done pulses at 19-cycle spacing and frame_count=3. Then drop run at sample 5 of frame 4 -> frame completes (16 writes), frame_count=4, FSM in IDLE.
REQ-045 reset=1 at sample 5 of a capture -> bram_en=0 the next cycle; busy=0, done=0, frame_count=0; run still high SHALL NOT restart the capture.
REQ-046 axi_aresetn pulsed low between clock edges mid-capture -> all outputs 0 before the next edge; after release, the first noise-enabled sample uses LFSR seed 16'hACE1.
